serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter N, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 op_a  input  N  first operand, captured on accepted start.
REQ-006 op_b  input  N  second operand, captured on accepted start.
REQ-007 carry_in  input  1  initial carry, captured on accepted start.
REQ-008 busy  output  1  high while the addition is in progress (RUN state).
REQ-009 done  output  1  single-cycle pulse; result valid.
REQ-010 sum  output  N  registered result; holds the last completed value.
REQ-011 carry_out  output  1  registered final carry of the last completed addition.

Function
REQ-012 The block SHALL perform N-bit addition bit-serially, LSB first, through exactly one instance of the team's existing 1-bit full adder FA.
- Ports: sum bit c, carry out ripout, inputs a, b, ripin.
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, encoded in a 2-bit register.
REQ-014 IDLE with start=1 SHALL, on the same edge:
- capture op_a, op_b and carry_in into internal shift and carry registers;
- clear the bit counter;
- enter RUN.
REQ-015 IDLE with start=0 SHALL remain in IDLE with no register change.
REQ-016 Each RUN cycle SHALL:
- drive the FA with the current LSB of the captured op_a and op_b and the carry register;
- shift both operand registers right by one;
- shift the FA sum bit into the MSB of an internal partial-sum register;
- load the carry register with the FA carry out;
- increment the bit counter.
REQ-017 RUN SHALL last exactly N cycles; on the edge that ends the Nth RUN cycle, the FSM SHALL:
- enter DONE;
- copy the partial sum into sum and the final carry into carry_out.
REQ-018 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL always go to IDLE on the next edge.
REQ-019 Latency: a start accepted at edge k SHALL give done=1 in the cycle after edge k+N, with sum and carry_out valid in that same cycle.
REQ-020 busy SHALL be 1 exactly in RUN; busy and done SHALL never both be 1.
REQ-021 start SHALL be ignored in RUN and DONE.
- A start held high continuously SHALL launch a new addition in the first IDLE cycle after DONE, giving one operation every N+2 cycles.
REQ-022 Changes on op_a, op_b or carry_in after acceptance SHALL NOT affect the result in progress.
REQ-023 sum and carry_out SHALL change only on entry to DONE (or on reset) and SHALL hold their value through IDLE and a subsequent RUN.
REQ-024 Arithmetic SHALL be unsigned modulo 2^N, with the (N+1)th bit on carry_out:
- sum = (op_a + op_b + carry_in) mod 2^N;
- carry_out = (op_a + op_b + carry_in) >> N.
REQ-025 The bit counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-026 rst_n=0 at a rising edge SHALL, in any state including mid-RUN:
- force IDLE;
- clear busy, done, sum, carry_out, the bit counter, the carry register and all shift registers to 0.
REQ-027 An operation interrupted by reset SHALL be discarded with no done pulse; start is ignored while rst_n=0.
REQ-028 After rst_n returns to 1, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-029 N=8: op_a=0xA5, op_b=0x3C, carry_in=0, one-cycle start -> busy high for 8 cycles; done pulse in the 9th cycle after the accept edge; sum=0xE1, carry_out=0.
REQ-030 N=8: 0xFF + 0x01, carry_in=0 -> sum=0x00, carry_out=1.
REQ-031 N=8: 0xFF + 0xFF, carry_in=1 -> sum=0xFF, carry_out=1.
REQ-032 N=8: start accepted, rst_n=0 after 4 RUN cycles -> next cycle busy=0, done=0, sum=0x00, carry_out=0, state IDLE, and no done pulse follows.
REQ-033 N=8: start held high for 30 cycles, with operands changed every cycle -> done pulses exactly 10 cycles apart; each result matches the operands present on its accept edge.
REQ-034 Exhaustive at N=2: all 32 (op_a, op_b, carry_in) combinations -> sum and carry_out match the reference sum; no pulse width on done exceeds 1 cycle.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: N-bit unsigned adder that works one bit per clock, LSB first.
// All bits go through a single 1-bit full adder (FA).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin an addition (sampled only in IDLE)
//   op_a/op_b  N-bit operands, captured on an accepted start
//   carry_in   initial carry, captured on an accepted start
//   busy       high for the N RUN cycles
//   done       one-cycle pulse when sum/carry_out are updated
//   sum        registered result of the last completed addition
//   carry_out  registered final carry of the last completed addition
//
// FA: 1-bit full adder.
//   a, b   operand bits
//   ripin  carry in
//   c      sum bit
//   ripout carry out

module FA (
  input  logic a,
  input  logic b,
  input  logic ripin,
  output logic c,
  output logic ripout
);
  assign c      = a ^ b ^ ripin;
  assign ripout = (a & b) | (ripin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         carry_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         carry_out
);
  // Wide enough to hold N, so the counter never wraps during an operation.
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_sh, b_sh, ps, ps_nxt;
  logic           cy;
  logic [CW-1:0]  cnt;
  logic           fa_s, fa_c;
  logic           last;

  FA u_fa (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .ripin  (cy),
    .c      (fa_s),
    .ripout (fa_c)
  );

  // The counter holds the number of bits already processed.
  // The Nth bit is processed when the counter reads N-1.
  assign last   = (cnt == CW'(N - 1));
  // The new sum bit enters at the MSB. After N shifts, bit 0 holds the LSB.
  assign ps_nxt = {fa_s, {(N-1){1'b0}}} | (ps >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      ps        <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh <= op_a;
          b_sh <= op_b;
          cy   <= carry_in;
          cnt  <= '0;
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          ps   <= ps_nxt;
          cy   <= fa_c;
          cnt  <= cnt + 1'b1;
          if (last) begin
            sum       <= ps_nxt;
            carry_out <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] op_a = '0, op_b = '0;
  logic       carry_in = 1'b0;
  logic       busy, done, carry_out;
  logic [7:0] sum;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ci2 = 1'b0;
  logic       busy2, done2, co2;
  logic [1:0] sum2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  serial_adder_ctrl #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op_a(a2), .op_b(b2),
    .carry_in(ci2), .busy(busy2), .done(done2), .sum(sum2), .carry_out(co2)
  );

  // Pulses start for one cycle and then scrambles the operands.
  // It watches 20 cycles and records the busy count, the cycle of the first done,
  // any busy/done overlap, the result at done, and the held result at the end.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output logic [7:0] s, output logic co, output int busy_cnt,
                        output int done_at, output int done_cnt, output bit overlap,
                        output logic [7:0] s_hold);
    busy_cnt = 0; done_at = 0; done_cnt = 0; overlap = 0; s = 'x; co = 1'bx;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; carry_in = ci;
    @(negedge clk);
    start = 1'b0; op_a = ~a; op_b = a ^ b; carry_in = ~ci;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin done_at = i; s = sum; co = carry_out; end
      end
      @(negedge clk);
    end
    s_hold = sum;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", sum); end
    total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", carry_out); end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [7:0] es, input logic ec);
    logic [7:0] s, sh; logic co; int bc, da, dc; bit ov;
    run_op(a, b, ci, s, co, bc, da, dc, ov, sh);
    total++; if (bc != 8) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=8", nm, bc); end
    total++; if (da != 9) begin bad++; $display("FAIL %s done_cycle got=%0d exp=9", nm, da); end
    total++; if (dc != 1) begin bad++; $display("FAIL %s done_count got=%0d exp=1", nm, dc); end
    total++; if (ov) begin bad++; $display("FAIL %s busy_done_overlap got=1 exp=0", nm); end
    total++; if (s !== es) begin bad++; $display("FAIL %s sum got=%h exp=%h", nm, s, es); end
    total++; if (co !== ec) begin bad++; $display("FAIL %s cout got=%b exp=%b", nm, co, ec); end
    total++; if (sh !== es) begin bad++; $display("FAIL %s sum_hold got=%h exp=%h", nm, sh, es); end
  endtask

  task automatic test_mid_reset;
    int seen_done = 0, seen_busy = 0;
    logic [7:0] s, sh; logic co; int bc, da, dc; bit ov;
    @(negedge clk);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    // The 4th RUN cycle is in progress here, so reset takes effect on the edge that ends it.
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL midrst_sum got=%h exp=00", sum); end
    total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL midrst_cout got=%b exp=0", carry_out); end
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done) seen_done++;
      if (busy) seen_busy++;
      @(negedge clk);
    end
    total++; if (seen_done != 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", seen_done); end
    total++; if (seen_busy != 0) begin bad++; $display("FAIL midrst_no_busy got=%0d exp=0", seen_busy); end
    run_op(8'h12, 8'h34, 1'b1, s, co, bc, da, dc, ov, sh);
    total++; if (s !== 8'h47 || co !== 1'b0 || da != 9)
      begin bad++; $display("FAIL post_reset_op got=%h/%b@%0d exp=47/0@9", s, co, da); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ea [40]; logic [7:0] eb [40]; logic ec [40];
    int dj [$];
    logic [8:0] ref9;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) begin
        dj.push_back(j);
        if (j >= 9) begin
          ref9 = {1'b0, ea[j-9]} + {1'b0, eb[j-9]} + {8'b0, ec[j-9]};
          total++;
          if ({carry_out, sum} !== ref9) begin
            bad++; $display("FAIL b2b_result j=%0d got=%b_%h exp=%b_%h", j, carry_out, sum, ref9[8], ref9[7:0]);
          end
        end
      end
      ea[j] = 8'(j * 37 + 11); eb[j] = 8'(j * 91 + 200); ec[j] = j[0];
      op_a = ea[j]; op_b = eb[j]; carry_in = ec[j];
      start = (j < 30);
    end
    start = 1'b0;
    total++; if (dj.size() != 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", dj.size()); end
    else begin
      total++; if (dj[0] != 9) begin bad++; $display("FAIL b2b_first got=%0d exp=9", dj[0]); end
      total++; if (dj[1] - dj[0] != 10 || dj[2] - dj[1] != 10)
        begin bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=10,10", dj[1]-dj[0], dj[2]-dj[1]); end
    end
  endtask

  task automatic test_exhaustive_n2;
    int da, wid;
    logic [2:0] ref3;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      start2 = 1'b1; a2 = k[1:0]; b2 = k[3:2]; ci2 = k[4];
      ref3 = {1'b0, k[1:0]} + {1'b0, k[3:2]} + {2'b0, k[4]};
      @(negedge clk);
      start2 = 1'b0; a2 = ~a2; b2 = ~b2;
      da = 0;
      for (int i = 1; i <= 8 && da == 0; i++) begin
        if (done2) begin
          da = i;
          total++;
          if ({co2, sum2} !== ref3) begin
            bad++; $display("FAIL n2_result k=%0d got=%b_%b exp=%b_%b", k, co2, sum2, ref3[2], ref3[1:0]);
          end
        end else @(negedge clk);
      end
      total++; if (da != 3) begin bad++; $display("FAIL n2_latency k=%0d got=%0d exp=3", k, da); end
      wid = 0;
      while (done2 && wid < 4) begin wid++; @(negedge clk); end
      total++; if (wid != 1) begin bad++; $display("FAIL n2_pulse_width k=%0d got=%0d exp=1", k, wid); end
    end
  endtask

  initial begin
    test_reset();
    test_add("basic_a5_3c", 8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0);
    test_add("ff_plus_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    test_add("ff_ff_ci",    8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    test_mid_reset();
    test_back_to_back();
    test_exhaustive_n2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
